vid_write_arbiter: RTL and testbench
====================================

Name: vid_write_arbiter

Overview:
- Sits between the c16 core's video write strobe (vid_wen, w_param, w_index, w_val) and the single-ported video memory.
- Scanout also reads that memory, and read requests always win the port.
- CPU writes are therefore buffered in a FIFO and drained into free cycles.
- A starvation counter guarantees that buffered writes make forward progress.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- AW, 3, log2(DEPTH).
- STARVE_LIMIT, 15, consecutive cycles the FIFO may be non-empty without a write before a write slot is forced; range 1..255.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset.
- vid_wen  in  1  CPU video write strobe, one cycle per write.
- w_param  in  2  CPU write parameter; forms mem_addr[12:11].
- w_index  in  11  CPU write index; forms mem_addr[10:0].
- w_val  in  16  CPU write data.
- rd_req  in  1  scanout read request, level-sensitive.
- rd_addr  in  13  scanout read address.
- rd_grant  out  1  memory port was given to scanout this cycle.
- mem_we  out  1  video memory write enable.
- mem_addr  out  13  video memory address.
- mem_wdata  out  16  video memory write data.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset: resetn is synchronous, active-low; clock clk.
  - While resetn=0: FIFO flushed (read/write pointers and level = 0), starvation counter = 0, overflow = 0.
  - Outputs during reset: rd_grant = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Reset asserted mid-operation discards all queued writes. Nothing is issued on the cycle after reset deasserts unless rd_req is high.
- Enqueue:
  - On a clk edge with vid_wen=1 the entry {w_param, w_index, w_val} is written.
  - Accepted if level < DEPTH, or if a pop occurs on the same edge (full + push + pop leaves level unchanged).
  - Otherwise the write is dropped and overflow is set to 1 until reset.
- Arbitration: decided each cycle from the current state; all memory outputs are registered.
  - Priority 1, forced write: FIFO non-empty and starve_cnt >= STARVE_LIMIT. Pop the head and register mem_we=1, mem_addr/mem_wdata from the head, rd_grant=0. Reset starve_cnt to 0.
  - Priority 2, read: rd_req=1. Register rd_grant=1, mem_we=0, mem_addr=rd_addr, mem_wdata=0. If the FIFO is non-empty, starve_cnt increments, saturating at 255.
  - Priority 3, write: FIFO non-empty. Pop and register the write as in priority 1, rd_grant=0, starve_cnt=0.
  - Otherwise idle: rd_grant=0, mem_we=0, mem_addr and mem_wdata hold their last values. If the FIFO is empty, starve_cnt=0.
- Latency:
  - A push on edge N is visible in level after edge N.
  - With rd_req=0, its write is issued at edge N+1, so mem_we is high in the cycle after N+1.
  - There is no bypass when the FIFO is empty.
- Throughput: at most one push and one pop per cycle.
- FIFO order: strict FIFO. Pointers wrap modulo DEPTH. level is computed as push − pop each cycle.
- Handshake with scanout:
  - rd_grant=1 in cycle C means the memory is addressed with the rd_addr sampled at the edge starting C.
  - Scanout must tolerate rd_grant=0 (a forced write) at most once every STARVE_LIMIT+1 cycles while the FIFO is busy.
- Entries are never reordered or merged. Writes to the same address are all issued, in order.

Test Plan:
- Single write, idle read side: rd_req=0; pulse vid_wen with w_param=2, w_index=0x005, w_val=0xBEEF at edge 0. Required: level=1 after edge 0; mem_we=1, mem_addr=0x1005, mem_wdata=0xBEEF after edge 1; level=0 after edge 1.
- Read priority: rd_req=1 continuously with rd_addr=0x0123, queue one write. Required:
  - rd_grant=1 and mem_addr=0x0123 for 15 cycles.
  - On the 16th cycle a forced write: rd_grant=0, mem_we=1.
  - Then rd_grant=1 again.
- Overflow: rd_req=1 with STARVE_LIMIT=255, push 9 writes on consecutive cycles. Required: full=1 after the 8th write, the 9th is dropped, overflow=1, level=8. Drop rd_req; 8 writes drain in push order on 8 consecutive cycles; overflow stays 1.
- Full + simultaneous push/pop: FIFO full, rd_req=0, vid_wen=1. Required: the head is written, the new entry is accepted, level stays 8, overflow stays 0.
- Reset mid-drain: 5 entries queued, assert resetn=0 for one cycle. Required: level=0, mem_we=0, rd_grant=0, overflow=0; no further writes are issued after release.
- Ordering under interleave: alternate rd_req on and off every cycle while pushing 4 writes to the same address with values 1,2,3,4. Required: mem_wdata is observed as 1,2,3,4 in order, and no read is lost while rd_req is high except at forced slots.

Source files
------------

// File: rtl/vid_write_arbiter.sv
// Video memory port arbiter: scanout reads own the single memory port, CPU
// video writes are queued in a FIFO and drained into cycles scanout leaves
// free. A starvation counter forces a write slot so queued writes always
// make forward progress even under continuous scanout.
module vid_write_arbiter #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AW           = 3,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          vid_wen,
  input  logic [1:0]    w_param,
  input  logic [10:0]   w_index,
  input  logic [15:0]   w_val,
  input  logic          rd_req,
  input  logic [12:0]   rd_addr,
  output logic          rd_grant,
  output logic          mem_we,
  output logic [12:0]   mem_addr,
  output logic [15:0]   mem_wdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overflow
);

  // Entry layout: {address[12:0], data[15:0]}
  localparam int unsigned EW = 29;
  localparam logic [AW:0] DEPTH_LVL  = (AW+1)'(DEPTH);
  localparam logic [7:0]  STARVE_LIM = 8'(STARVE_LIMIT);

  logic [EW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    starve_q, starve_d;
  logic          overflow_q;
  logic          rd_grant_q, mem_we_q;
  logic [12:0]   mem_addr_q;
  logic [15:0]   mem_wdata_q;

  logic          nonempty;
  logic          is_full;
  logic          forced;
  logic          do_read;
  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] head;

  // Port decision for this cycle, taken purely from current state and rd_req
  always_comb begin
    nonempty = (level_q != '0);
    is_full  = (level_q == DEPTH_LVL);
    forced   = nonempty && (starve_q >= STARVE_LIM);
    do_read  = !forced && rd_req;
    pop      = forced || (!rd_req && nonempty);
    // A full FIFO still accepts a push when the head leaves on the same edge
    push     = vid_wen && (!is_full || pop);
    drop     = vid_wen && !push;
    head     = fifo_mem[rd_ptr_q];
  end

  // Occupancy and starvation counter next-state
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end

    starve_d = starve_q;
    if (!nonempty || pop) begin
      starve_d = '0;
    end else if (do_read && (starve_q != 8'hFF)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // FIFO storage; contents need no reset since pointers and level gate them
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {w_param, w_index, w_val};
    end
  end

  // FIFO pointers, occupancy, starvation counter and sticky overflow
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      starve_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q  <= level_d;
      starve_q <= starve_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Registered memory port; address/data hold their last value when idle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_grant_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (pop) begin
      rd_grant_q  <= 1'b0;
      mem_we_q    <= 1'b1;
      mem_addr_q  <= head[28:16];
      mem_wdata_q <= head[15:0];
    end else if (do_read) begin
      rd_grant_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= rd_addr;
      mem_wdata_q <= '0;
    end else begin
      rd_grant_q  <= 1'b0;
      mem_we_q    <= 1'b0;
    end
  end

  // Output mapping
  always_comb begin
    rd_grant  = rd_grant_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    level     = level_q;
    full      = is_full;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_vid_write_arbiter.sv
// Directed bench for vid_write_arbiter. Expected memory writes are queued
// when the CPU write is driven and popped by a monitor when mem_we appears.
module tb_vid_write_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        vid_wen;
  logic [1:0]  w_param;
  logic [10:0] w_index;
  logic [15:0] w_val;
  logic        rd_req;
  logic [12:0] rd_addr;
  logic        rd_grant;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [3:0]  level;
  logic        full;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [28:0] sb[$];

  vid_write_arbiter #(
    .DEPTH(8),
    .AW(3),
    .STARVE_LIMIT(15)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .vid_wen(vid_wen),
    .w_param(w_param),
    .w_index(w_index),
    .w_val(w_val),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_grant(rd_grant),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .level(level),
    .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [1:0] p, input logic [10:0] idx, input logic [15:0] v,
                         input bit accept);
    vid_wen = 1'b1;
    w_param = p;
    w_index = idx;
    w_val   = v;
    if (accept) sb.push_back({p, idx, v});
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    sb.delete();
  endtask

  // Every issued write must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (resetn && mem_we) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {3'b0, mem_addr, mem_wdata}, 32'hDEAD_0000);
      end else begin
        logic [28:0] e;
        e = sb.pop_front();
        check("write_order", {3'b0, mem_addr, mem_wdata}, {3'b0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    vid_wen = 1'b0;
    w_param = '0;
    w_index = '0;
    w_val   = '0;
    rd_req  = 1'b0;
    rd_addr = '0;

    // Reset state
    step();
    step();
    check("rst_rd_grant", 32'(rd_grant), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    resetn = 1'b1;
    step();
    check("post_rst_idle", 32'(mem_we), 32'd0);

    // Single write with idle read side
    push_wr(2'd2, 11'h005, 16'hBEEF, 1'b1);
    step();
    vid_wen = 1'b0;
    check("single_level1", 32'(level), 32'd1);
    check("single_no_bypass", 32'(mem_we), 32'd0);
    step();
    check("single_we", 32'(mem_we), 32'd1);
    check("single_addr", 32'(mem_addr), 32'h1005);
    check("single_data", 32'(mem_wdata), 32'hBEEF);
    check("single_level0", 32'(level), 32'd0);
    step();
    check("idle_we", 32'(mem_we), 32'd0);
    check("idle_addr_hold", 32'(mem_addr), 32'h1005);

    // Read priority with a forced slot after STARVE_LIMIT reads
    rd_req  = 1'b1;
    rd_addr = 13'h0123;
    step();
    check("rd_grant_empty", 32'(rd_grant), 32'd1);
    push_wr(2'd1, 11'h7FF, 16'h1234, 1'b1);
    step();
    vid_wen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      check("prio_grant", {7'b0, 13'(mem_addr), 10'b0, rd_grant, mem_we}, {7'b0, 13'h0123, 10'b0, 2'b10});
    end
    step();
    check("forced_grant", 32'(rd_grant), 32'd0);
    check("forced_we", 32'(mem_we), 32'd1);
    step();
    check("regrant", 32'(rd_grant), 32'd1);
    check("regrant_addr", 32'(mem_addr), 32'h0123);
    rd_req = 1'b0;
    step();

    // Overflow: nine pushes while reads hold the port
    rd_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_wr(2'd0, 11'(i), 16'(16'hA000 + i), i < 8);
      step();
      if (i == 7) begin
        check("ovf_full_at_8", 32'(full), 32'd1);
        check("ovf_level_at_8", 32'(level), 32'd8);
        check("ovf_clear_at_8", 32'(overflow), 32'd0);
      end
    end
    vid_wen = 1'b0;
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd8);
    rd_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("ovf_drain_we", 32'(mem_we), 32'd1);
    end
    step();
    check("ovf_drained_we", 32'(mem_we), 32'd0);
    check("ovf_drained_level", 32'(level), 32'd0);
    check("ovf_still_set", 32'(overflow), 32'd1);
    check("ovf_sb_empty", 32'(sb.size()), 32'd0);

    do_reset();
    check("rst_clears_ovf", 32'(overflow), 32'd0);
    resetn = 1'b1;

    // Full FIFO with simultaneous push and pop
    rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_wr(2'd3, 11'(16 + i), 16'(16'hC000 + i), 1'b1);
      step();
    end
    check("fp_full", 32'(full), 32'd1);
    rd_req = 1'b0;
    push_wr(2'd3, 11'h100, 16'hC0DE, 1'b1);
    step();
    vid_wen = 1'b0;
    check("fp_level", 32'(level), 32'd8);
    check("fp_overflow", 32'(overflow), 32'd0);
    check("fp_we", 32'(mem_we), 32'd1);
    for (int i = 0; i < 8; i++) step();
    step();
    check("fp_drained", 32'(level), 32'd0);
    check("fp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-drain discards queued writes
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_wr(2'd1, 11'(32 + i), 16'(16'h5000 + i), 1'b1);
      step();
    end
    vid_wen = 1'b0;
    check("mid_level5", 32'(level), 32'd5);
    do_reset();
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_grant", 32'(rd_grant), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    resetn = 1'b1;
    rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_no_write", 32'(mem_we), 32'd0);
    end

    // Interleaved reads with four writes to one address
    for (int c = 0; c < 12; c++) begin
      logic req;
      req    = (c % 2 == 1);
      rd_req = req;
      if (c < 4) push_wr(2'd0, 11'h042, 16'(c + 1), 1'b1);
      else vid_wen = 1'b0;
      step();
      check("il_grant", 32'(rd_grant), 32'(req));
    end
    vid_wen = 1'b0;
    rd_req  = 1'b0;
    step();
    check("il_sb_empty", 32'(sb.size()), 32'd0);
    check("il_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
